// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: baud/phase sequencer for the PRBS + polyphase FIR transmit chain, with burst/continuous runs and zero-symbol flush.
module mod_seq_ctrl #(
  parameter int OVER_SAMP = 8,
  parameter int N_BAUDS   = 7,
  parameter int NB_LEN    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enable,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_mode,
  input  logic [NB_LEN-1:0]            i_burst_len,
  output logic                         o_valid,
  output logic [$clog2(OVER_SAMP)-1:0] o_phase,
  output logic                         o_prbs_enable,
  output logic                         o_fir_enable,
  output logic                         o_zero_sym,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int PW = $clog2(OVER_SAMP);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t            state;
  logic [PW-1:0]     phase;
  logic [NB_LEN-1:0] cnt, len_q;
  logic              mode_q, stop_pend;
  logic              last, active;
  assign last   = phase == PW'(OVER_SAMP - 1);
  assign active = state == RUN || state == FLUSH;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      phase     <= '0;
      cnt       <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      stop_pend <= 1'b0;
    end else if (i_enable) begin
      case (state)
        IDLE: if (i_start && (i_mode || i_burst_len != '0)) begin
          len_q  <= i_burst_len;
          mode_q <= i_mode;
          phase  <= '0;
          cnt    <= NB_LEN'(1);
          state  <= RUN;
        end
        RUN: begin
          phase <= phase + 1'b1;
          if (last) begin
            // a stop seen on the final phase still ends this baud, never a later one
            if ((!mode_q && cnt == len_q) || stop_pend || i_stop) begin
              state     <= FLUSH;
              cnt       <= NB_LEN'(1);
              stop_pend <= 1'b0;
            end else
              cnt <= cnt + 1'b1;
          end else if (i_stop)
            stop_pend <= 1'b1;
        end
        FLUSH: begin
          phase <= phase + 1'b1;
          if (last) begin
            if (cnt == NB_LEN'(N_BAUDS)) state <= DONE;
            else cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_phase       = phase;
  assign o_valid       = active && phase == '0 && i_enable;
  assign o_prbs_enable = state == RUN && phase == '0 && i_enable;
  assign o_fir_enable  = active && i_enable;
  assign o_zero_sym    = state == FLUSH;
  assign o_busy        = state != IDLE;
  assign o_done        = state == DONE && i_enable;
endmodule

// File: tb/tb_mod_seq_ctrl.sv
// tb_mod_seq_ctrl: scoreboard bench; scenarios push expected strobe/done events, a negedge monitor pops and compares.
module tb_mod_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        i_enable = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_mode = 1'b0;
  logic [15:0] i_burst_len = '0;
  logic        o_valid, o_prbs_enable, o_fir_enable, o_zero_sym, o_busy, o_done;
  logic [2:0]  o_phase;
  int          cyc = 0, base = 0, errors = 0, checks = 0;
  typedef struct {int c; logic zero; logic prbs; logic done;} ev_t;
  ev_t exp_q[$];

  mod_seq_ctrl dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_burst_len(i_burst_len), .o_valid(o_valid), .o_phase(o_phase),
    .o_prbs_enable(o_prbs_enable), .o_fir_enable(o_fir_enable), .o_zero_sym(o_zero_sym),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid === 1'b1 || o_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d valid=%b done=%b, required no event", cyc - base, o_valid, o_done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (cyc - base != e.c || o_zero_sym !== e.zero || o_prbs_enable !== e.prbs || o_done !== e.done || o_phase !== 3'd0) begin
          errors++;
          $display("FAIL event: got cycle=%0d zero=%b prbs=%b done=%b phase=%0d, required cycle=%0d zero=%b prbs=%b done=%b phase=0",
                   cyc - base, o_zero_sym, o_prbs_enable, o_done, o_phase, e.c, e.zero, e.prbs, e.done);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  function automatic int all_out();
    return int'({o_valid, o_phase, o_prbs_enable, o_fir_enable, o_zero_sym, o_busy, o_done});
  endfunction

  // 3-baud run then 7-baud flush; cycles at/after gap_at are delayed by gap disabled cycles
  task automatic scen(input logic mode, input int stop_a, stop_b, en_from, en_to, start_b, rst_c, ncyc);
    int gap, limit, done_c;
    gap    = en_from >= 0 ? en_to - en_from + 1 : 0;
    limit  = rst_c >= 0 ? rst_c : 1000;
    done_c = 81 + gap;
    for (int k = 0; k < 10; k++) begin
      int c;
      c = 1 + 8 * k;
      if (en_from >= 0 && c >= en_from) c += gap;
      if (c <= limit) exp_q.push_back('{c, k >= 3, k < 3, 1'b0});
    end
    if (done_c <= limit) exp_q.push_back('{done_c, 1'b0, 1'b0, 1'b1});
    base = cyc;
    i_mode = mode;
    i_burst_len = 16'd3;
    for (int c = 0; c < ncyc; c++) begin
      i_start  = c == 0 || c == start_b;
      i_stop   = c == stop_a || c == stop_b;
      i_enable = !(c >= en_from && c <= en_to && en_from >= 0);
      rst      = c != rst_c;
      #1;
      check("busy", int'(o_busy), int'(c >= 1 && c <= done_c && !(rst_c >= 0 && c > rst_c)));
      if (!i_enable) check("frozen", int'({o_fir_enable, o_valid, o_phase}), 1);
      if (rst_c >= 0 && c > rst_c) check("post_reset_zero", all_out(), 0);
      @(posedge clk); #1;
    end
    i_start = 1'b0; i_stop = 1'b0; i_enable = 1'b1; rst = 1'b1;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) begin
      {i_start, i_stop, i_mode, i_enable} = 4'($urandom);
      i_burst_len = 16'($urandom);
      @(posedge clk); #1;
      check("reset_outputs", all_out(), 0);
    end
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_mode = 1'b0; i_enable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_after_reset", all_out(), 0);
    end
    i_burst_len = '0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) begin
      check("zero_len_ignored", int'(o_busy), 0);
      @(posedge clk); #1;
    end
    scen(1'b0, -1, -1, -1, -1, -1, -1, 85);
    scen(1'b1, 20, 30, -1, -1, -1, -1, 85);
    scen(1'b0, -1, -1, 10, 14, -1, -1, 90);
    scen(1'b0, -1, -1, -1, -1, 5, -1, 85);
    scen(1'b0, -1, -1, -1, -1, -1, 40, 45);
    scen(1'b0, -1, -1, -1, -1, -1, -1, 85);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod_seq_ctrl.md
Name: mod_seq_ctrl

Overview:
Sequencer for the modulator transmit chain: PRBS generator followed by the oversampled polyphase FIR shaping filter.
- Generates the baud strobe and the polyphase phase index (0..OVER_SAMP-1) that drive the filter.
- Gates the PRBS so it advances once per baud.
- Runs either finite bursts or continuous transmission.
- After each transmission, flushes the filter symbol shift register with N_BAUDS zero symbols so no stale energy remains at the output.

Parameters:
OVER_SAMP, 8, samples per baud; must be a power of 2 and >= 2.
N_BAUDS, 7, filter span in bauds; number of zero symbols injected during flush.
NB_LEN, 16, width of the burst-length input and of the baud counter.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-low; sampled on the clk rising edge.
i_enable  in  1  global clock enable; low freezes all state, counters and registers.
i_start  in  1  start request; sampled only in IDLE.
i_stop  in  1  stop request; sampled only in RUN.
i_mode  in  1  0 = burst of i_burst_len symbols, 1 = continuous until stop.
i_burst_len  in  NB_LEN  burst symbol count; captured on an accepted start.
o_valid  out  1  baud strobe to the filter; high for one cycle at phase 0 of each baud in RUN and FLUSH.
o_phase  out  clog2(OVER_SAMP)  polyphase index for filter coefficient selection.
o_prbs_enable  out  1  PRBS advance strobe; equals o_valid in RUN only.
o_fir_enable  out  1  filter clock enable; high while in RUN or FLUSH and i_enable is high.
o_zero_sym  out  1  high in FLUSH; forces the filter symbol input to 0.
o_busy  out  1  high in RUN, FLUSH and DONE.
o_done  out  1  one-cycle pulse in DONE.

Behaviour:
- FSM states: IDLE, RUN, FLUSH, DONE.
- Registered state: state, phase counter (clog2(OVER_SAMP) bits), baud counter cnt (NB_LEN bits), captured length len_q, mode_q, stop_pend.
- Reset (rst=0 at an edge):
  - state goes to IDLE; phase, cnt, len_q and stop_pend are cleared.
  - All outputs are 0 from the following cycle.
  - Reset overrides everything, including mid-RUN or mid-FLUSH; no o_done is produced.
- i_enable=0: every register holds its value. o_valid, o_prbs_enable, o_fir_enable and o_done are forced to 0 (combinational gating with i_enable). o_busy, o_zero_sym and o_phase reflect the held state.
- IDLE:
  - A start is accepted when i_start=1, i_enable=1, and either i_mode=1 or i_burst_len!=0. On acceptance: capture len_q and mode_q, phase=0, cnt=1, go to RUN.
  - A burst start with i_burst_len=0 is ignored and the block stays in IDLE.
- Latency: start accepted at edge t gives RUN, phase 0 and o_valid=1 in cycle t+1.
- Phase counter: while in RUN or FLUSH with i_enable=1, phase increments each cycle and wraps from OVER_SAMP-1 to 0. o_valid = (phase==0) & i_enable.
- Baud counter: at each wrap to 0, cnt increments. In burst mode, cnt saturates at len_q.
- RUN exit, evaluated only at phase==OVER_SAMP-1 with i_enable=1:
  - Burst mode (mode_q=0) with cnt==len_q: go to FLUSH.
  - Any mode with stop_pend=1: go to FLUSH.
  - On exit to FLUSH: cnt=1, stop_pend=0.
  - RUN therefore lasts exactly len_q*OVER_SAMP enabled cycles; a baud is never truncated.
- Stop: i_stop=1 in RUN sets stop_pend. A stop arriving at phase OVER_SAMP-1 takes effect at the same edge. i_stop in other states is ignored. Stop in burst mode ends the burst early at the next baud boundary.
- FLUSH:
  - o_zero_sym=1 and o_prbs_enable=0.
  - Exactly N_BAUDS strobes are issued (N_BAUDS*OVER_SAMP enabled cycles).
  - At phase==OVER_SAMP-1 with cnt==N_BAUDS: go to DONE.
- DONE: lasts one enabled cycle with o_done=1, then returns to IDLE.
- i_start while in RUN, FLUSH or DONE is ignored; it is not queued.
- Outputs are decoded from registered state plus i_enable gating only; there are no other combinational input-to-output paths.

Test Plan:
1. rst=0 for 3 cycles with random inputs -> every output 0. Release reset -> block stays in IDLE with o_busy=0.
2. Burst, defaults, i_burst_len=3, start in cycle 0:
   - o_valid and o_prbs_enable in cycles 1, 9, 17.
   - o_zero_sym in cycles 25-80, with o_valid in cycles 25, 33, 41, 49, 57, 65, 73.
   - o_done in cycle 81; o_busy in cycles 1-81; IDLE from cycle 82.
3. Continuous mode, start in cycle 0, i_stop pulse in cycle 20 (phase 3) -> RUN ends after cycle 24, FLUSH runs cycles 25-80, o_done in cycle 81. A second i_stop in cycle 30 has no effect.
4. Burst length 3, i_enable=0 for cycles 10-14 -> outputs frozen and strobes masked. Subsequent strobes are at cycles 22, 30, ...; o_done in cycle 86.
5. i_mode=0 with i_burst_len=0 plus i_start -> stays in IDLE, o_busy=0. In a running burst, i_start in cycle 5 -> ignored, timing identical to scenario 2.
6. rst=0 in cycle 40 (mid-FLUSH) -> IDLE and all outputs 0 from cycle 41; no o_done. A new start in cycle 45 runs normally.
